// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix adder and the result streamer.
// MATRIX_STREAM_STATUS_EN adds the trailing overflow status beat.
package matrix_pkg;

  localparam int ELEM_W   = 8;
  localparam int DIM      = 5;
  localparam int MATRIX_W = DIM * DIM * ELEM_W;
  localparam int IDX_W    = 3;
  localparam int FLAT_W   = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEND   = 2'd1
`ifdef MATRIX_STREAM_STATUS_EN
    ,
    ST_STATUS = 2'd2
`endif
  } stream_state_t;

endpackage

// File: rtl/matrix_index_counter.sv
// Row-major row/col counter for the result streamer; the row wraps
// past DIM-1 to DIM, which doubles as the status beat coordinate.
module matrix_index_counter #(
  parameter int DIM = matrix_pkg::DIM
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          advance,
  output logic [matrix_pkg::IDX_W-1:0]  row,
  output logic [matrix_pkg::IDX_W-1:0]  col,
  output logic [matrix_pkg::FLAT_W-1:0] flat_idx,
  output logic                          last_elem
);
  import matrix_pkg::*;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col == IDX_W'(DIM - 1)) begin
        col <= '0;
        row <= row + IDX_W'(1);
      end else begin
        col <= col + IDX_W'(1);
      end
    end
  end

  always_comb begin
    flat_idx  = FLAT_W'(row) * FLAT_W'(DIM) + FLAT_W'(col);
    last_elem = (row == IDX_W'(DIM - 1)) && (col == IDX_W'(DIM - 1));
  end

endmodule

// File: rtl/matrix_result_streamer.sv
// Captures a packed DIM x DIM result matrix on start and streams it row-major
// over valid/ready. MATRIX_STREAM_STATUS_EN appends an overflow status beat.
module matrix_result_streamer #(
  parameter int ELEM_W = matrix_pkg::ELEM_W,
  parameter int DIM    = matrix_pkg::DIM
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [DIM*DIM*ELEM_W-1:0]    matrix_in,
  input  logic                         overflow_in,
  output logic                         busy,
  output logic [ELEM_W-1:0]            out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic [matrix_pkg::IDX_W-1:0] out_row,
  output logic [matrix_pkg::IDX_W-1:0] out_col,
  output logic                         overflow_out,
  output logic                         done
);
  import matrix_pkg::*;

  stream_state_t state, state_next;

  logic [DIM*DIM*ELEM_W-1:0] cap;
  logic [FLAT_W-1:0]         flat_idx;
  logic [FLAT_W-1:0]         next_flat;
  logic                      last_elem;
  logic                      hs;
  logic                      capture;
  logic                      cnt_clear;
  logic                      cnt_adv;
  logic                      finish;

  matrix_index_counter #(.DIM(DIM)) u_index (
    .clk       (clk),
    .reset     (reset),
    .clear     (cnt_clear),
    .advance   (cnt_adv),
    .row       (out_row),
    .col       (out_col),
    .flat_idx  (flat_idx),
    .last_elem (last_elem)
  );

  assign hs        = out_valid && out_ready;
  assign next_flat = flat_idx + FLAT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    cnt_clear  = 1'b0;
    cnt_adv    = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          capture    = 1'b1;
          cnt_clear  = 1'b1;
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        if (hs) begin
          if (last_elem) begin
`ifdef MATRIX_STREAM_STATUS_EN
            cnt_adv    = 1'b1;
            state_next = ST_STATUS;
`else
            cnt_clear  = 1'b1;
            finish     = 1'b1;
            state_next = ST_IDLE;
`endif
          end else begin
            cnt_adv = 1'b1;
          end
        end
      end
`ifdef MATRIX_STREAM_STATUS_EN
      ST_STATUS: begin
        if (hs) begin
          cnt_clear  = 1'b1;
          finish     = 1'b1;
          state_next = ST_IDLE;
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  // Beat registers load the element the counter is about to point at, so the
  // payload changes in the same edge as the coordinates and holds otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap          <= '0;
      overflow_out <= 1'b0;
      out_data     <= '0;
      out_last     <= 1'b0;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done      <= finish;
      out_valid <= (state_next != ST_IDLE);
      busy      <= (state_next != ST_IDLE);
      if (capture) begin
        cap          <= matrix_in;
        overflow_out <= overflow_in;
        out_data     <= matrix_in[ELEM_W-1:0];
        out_last     <= 1'b0;
      end else if (finish) begin
        out_data <= '0;
        out_last <= 1'b0;
      end else if (cnt_adv) begin
`ifdef MATRIX_STREAM_STATUS_EN
        if (last_elem) begin
          out_data <= ELEM_W'(overflow_out);
          out_last <= 1'b1;
        end else begin
          out_data <= cap[int'(next_flat)*ELEM_W +: ELEM_W];
          out_last <= 1'b0;
        end
`else
        out_data <= cap[int'(next_flat)*ELEM_W +: ELEM_W];
        out_last <= (next_flat == FLAT_W'(DIM*DIM - 1));
`endif
      end
    end
  end

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Scoreboard bench for matrix_result_streamer: stimulus pushes expected beats,
// a negedge monitor pops and compares them on each handshake.
module tb_matrix_result_streamer;

  typedef struct {
    logic [7:0] data;
    logic [2:0] row;
    logic [2:0] col;
    logic       last;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [199:0] matrix_in;
  logic         overflow_in;
  logic         busy;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic [2:0]   out_row;
  logic [2:0]   out_col;
  logic         overflow_out;
  logic         done;

  int    checks = 0;
  int    errors = 0;
  int    done_cnt = 0;
  int    ready_mode = 0;
  logic  last_hs_prev = 1'b0;
  beat_t exp_q[$];

  matrix_result_streamer #(.ELEM_W(8), .DIM(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .matrix_in    (matrix_in),
    .overflow_in  (overflow_in),
    .busy         (busy),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .out_row      (out_row),
    .out_col      (out_col),
    .overflow_out (overflow_out),
    .done         (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // out_ready driver: constant high, or repeating 1,0,0,1
  initial begin
    logic [3:0] pat;
    int k;
    pat = 4'b1001;
    k = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) begin
        out_ready = 1'b1;
      end else begin
        out_ready = pat[3-k];
        k = (k + 1) % 4;
      end
    end
  end

  // Monitor: compare the presented beat with the queue head every cycle it is
  // valid (covers stall hold), pop on handshake, and check the done pulse.
  always @(negedge clk) begin
    if (reset) begin
      last_hs_prev = 1'b0;
    end else begin
      checks++;
      if (last_hs_prev) begin
        if (!(done && !busy && !out_valid)) begin
          errors++;
          $display("FAIL done_after_last: done=%0b busy=%0b valid=%0b required 1 0 0", done, busy, out_valid);
        end
      end else if (done) begin
        errors++;
        $display("FAIL spurious_done: done=%0b required 0", done);
      end
      last_hs_prev = 1'b0;
      if (done) done_cnt++;
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: data=%02h row=%0d col=%0d with nothing expected", out_data, out_row, out_col);
        end else begin
          if (out_data !== exp_q[0].data || out_row !== exp_q[0].row ||
              out_col !== exp_q[0].col || out_last !== exp_q[0].last) begin
            errors++;
            $display("FAIL beat: got data=%02h row=%0d col=%0d last=%0b required data=%02h row=%0d col=%0d last=%0b",
                     out_data, out_row, out_col, out_last,
                     exp_q[0].data, exp_q[0].row, exp_q[0].col, exp_q[0].last);
          end
          if (out_ready) begin
            last_hs_prev = exp_q[0].last;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  task automatic push_stream(input logic [199:0] m, input logic ovf);
    for (int i = 0; i < 25; i++) begin
      beat_t b;
      b.data = m[i*8 +: 8];
      b.row  = 3'(i / 5);
      b.col  = 3'(i % 5);
`ifdef MATRIX_STREAM_STATUS_EN
      b.last = 1'b0;
`else
      b.last = (i == 24);
`endif
      exp_q.push_back(b);
    end
`ifdef MATRIX_STREAM_STATUS_EN
    begin
      beat_t s;
      s.data = {7'b0, ovf};
      s.row  = 3'd5;
      s.col  = 3'd0;
      s.last = 1'b1;
      exp_q.push_back(s);
    end
`endif
  endtask

  // Called at posedge+#1; start is sampled at the next edge
  task automatic issue_start(input logic [199:0] m, input logic ovf);
    matrix_in   = m;
    overflow_in = ovf;
    start       = 1'b1;
    push_stream(m, ovf);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("valid_after_start", {30'd0, out_valid, busy}, 32'd3);
    check("overflow_captured", {31'd0, overflow_out}, {31'd0, ovf});
  endtask

  task automatic wait_done();
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      if (done) return;
    end
    errors++;
    $display("FAIL done_timeout: no done within 400 cycles");
  endtask

  task automatic check_all_zero(input string name);
    check(name, {busy, out_data, out_valid, out_last, out_row, out_col, overflow_out, done}, 32'd0);
  endtask

  initial begin
    logic [199:0] m_inc, m_alt, m_neg;
    logic [23:0]  neg_pat;
    neg_pat = 24'h80FF7F;
    for (int i = 0; i < 25; i++) begin
      m_inc[i*8 +: 8] = 8'(i + 1);
      m_alt[i*8 +: 8] = 8'(8'hA0 + i);
      m_neg[i*8 +: 8] = neg_pat[(2 - (i % 3))*8 +: 8];
    end

    reset       = 1'b1;
    start       = 1'b0;
    matrix_in   = '0;
    overflow_in = 1'b0;
    #12;
    check_all_zero("reset_outputs");
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("idle_outputs");

    // Basic stream
    issue_start(m_inc, 1'b0);
    wait_done();
    check("busy_with_done", {31'd0, busy}, 32'd0);
    check("overflow_hold0", {31'd0, overflow_out}, 32'd0);
    @(posedge clk);
    #1;

    // Backpressure
    ready_mode = 1;
    issue_start(m_inc, 1'b0);
    wait_done();
    ready_mode = 0;
    @(posedge clk);
    #1;

    // Mid-stream start and matrix change during beat 10
    issue_start(m_inc, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    matrix_in = m_alt;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();
    check("midstream_queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;

    // Negative values with overflow
    issue_start(m_neg, 1'b1);
    wait_done();
    check("overflow_hold1", {31'd0, overflow_out}, 32'd1);
    @(posedge clk);
    #1;

    // Back-to-back: second start in the done cycle
    issue_start(m_inc, 1'b0);
    wait_done();
    issue_start(m_neg, 1'b1);
    wait_done();
    @(posedge clk);
    #1;

    // Reset during beat 12
    issue_start(m_alt, 1'b1);
    repeat (11) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset_outputs");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("no_done_after_reset", 32'(done_cnt), 32'd6);
    issue_start(m_inc, 1'b0);
    wait_done();
    @(posedge clk);
    #1;

    check("done_count", 32'(done_cnt), 32'd7);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
